// File: rtl/pwm_rampa_ctrl_if.sv
// Request/status bundle between a ramp requester and pwm_rampa_ctrl.
// Latency: none, wires only.
// Backpressure: none; the requester watches busy/done before issuing start.
interface pwm_rampa_ctrl_if #(
    parameter int R      = 6,
    parameter int STEP_W = 16
);
    logic              start;
    logic [R-1:0]      target;
    logic [STEP_W-1:0] step_div;
    logic              busy;
    logic              done;
    logic [R-1:0]      duty;
    logic              pwm_out;

    modport master (
        output start, target, step_div,
        input  busy, done, duty, pwm_out
    );

    modport slave (
        input  start, target, step_div,
        output busy, done, duty, pwm_out
    );
endinterface

// File: rtl/pwm_rampa_ctrl.sv
// PWM generator with a one-LSB-per-step duty ramp toward a requested target; optional PWM_RAMP_RETARGET_EN.
// Latency: busy one edge after start, first step after step_div+1 cycles, duty visible at next PWM wrap.
// Backpressure: start while busy is dropped, or re-targets the ramp when PWM_RAMP_RETARGET_EN is defined.
module pwm_rampa_ctrl #(
    parameter int R      = 6,
    parameter int STEP_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    pwm_rampa_ctrl_if.slave bus
);
`ifdef PWM_RAMP_RETARGET_EN
    localparam bit RETARGET = 1'b1;
`else
    localparam bit RETARGET = 1'b0;
`endif

    typedef enum logic {IDLE, RAMP} state_t;

    state_t            state, state_nxt;
    logic [R-1:0]      cnt;
    logic [R-1:0]      duty_active;
    logic [R-1:0]      duty_q, duty_nxt;
    logic [R-1:0]      tgt_q, tgt_nxt;
    logic [STEP_W-1:0] div_q, div_nxt;
    logic [STEP_W-1:0] tick, tick_nxt;
    logic              done_q, done_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            duty_active <= '0;
            duty_q      <= '0;
            tgt_q       <= '0;
            div_q       <= '0;
            tick        <= '0;
            done_q      <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt + 1'b1;
            // Sampling the pre-update duty keeps the period that starts now consistent.
            if (cnt == {R{1'b1}})
                duty_active <= duty_q;
            duty_q <= duty_nxt;
            tgt_q  <= tgt_nxt;
            div_q  <= div_nxt;
            tick   <= tick_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        duty_nxt  = duty_q;
        tgt_nxt   = tgt_q;
        div_nxt   = div_q;
        tick_nxt  = tick;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    tgt_nxt  = bus.target;
                    div_nxt  = bus.step_div;
                    tick_nxt = '0;
                    if (bus.target == duty_q)
                        done_nxt = 1'b1;
                    else
                        state_nxt = RAMP;
                end
            end
            RAMP: begin
                if (RETARGET && bus.start) begin
                    tgt_nxt  = bus.target;
                    div_nxt  = bus.step_div;
                    tick_nxt = '0;
                    if (bus.target == duty_q) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else if (tick == div_q) begin
                    tick_nxt = '0;
                    // Direction comes from the compare, so the step can never overshoot or wrap.
                    duty_nxt = (tgt_q > duty_q) ? duty_q + 1'b1 : duty_q - 1'b1;
                    if (duty_nxt == tgt_q) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    tick_nxt = tick + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy    = (state == RAMP);
    assign bus.done    = done_q;
    assign bus.duty    = duty_q;
    assign bus.pwm_out = (cnt < duty_active);
endmodule

// File: tb/tb_pwm_rampa_ctrl.sv
// Self-checking bench for pwm_rampa_ctrl: arithmetic ramp/PWM model plus directed literal checks.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: n/a; start is driven directly, including while busy.
module tb_pwm_rampa_ctrl;
    localparam int R  = 6;
    localparam int SW = 16;
    localparam int P  = 1 << R;
`ifdef PWM_RAMP_RETARGET_EN
    localparam bit RETARGET = 1'b1;
`else
    localparam bit RETARGET = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pwm_rampa_ctrl_if #(.R(R), .STEP_W(SW)) bus ();
    pwm_rampa_ctrl #(.R(R), .STEP_W(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // Model: a ramp is described by its start edge, origin, target and divider;
    // the duty at any edge is origin +/- min(distance, elapsed/(div+1)).
    int m_cnt = 0, m_duty = 0, m_dact = 0, m_done = 0, cyc = 0;
    bit r_act = 1'b0;
    int r_start = 0, r_d0 = 0, r_tgt = 0, r_div = 0;

    int busy_cnt = 0, done_cnt = 0;
    bit glitch_en = 1'b0, g_started = 1'b0;
    int g_high = 0, g_prev_high = 0;
    int g_prev_pwm = 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int pre_duty, pre_cnt, n, steps;
        pre_duty = m_duty;
        pre_cnt  = m_cnt;
        if (reset) begin
            m_cnt = 0; m_duty = 0; m_dact = 0; m_done = 0; r_act = 1'b0; cyc = 0;
            return;
        end
        cyc++;
        m_done = 0;
        if (pre_cnt == P - 1)
            m_dact = pre_duty;
        m_cnt = (pre_cnt + 1) % P;
        if (bus.start && (!r_act || RETARGET)) begin
            if (int'(bus.target) == pre_duty) begin
                r_act  = 1'b0;
                m_done = 1;
            end else begin
                r_act   = 1'b1;
                r_start = cyc;
                r_d0    = pre_duty;
                r_tgt   = int'(bus.target);
                r_div   = int'(bus.step_div);
            end
        end else if (r_act) begin
            n     = (r_tgt > r_d0) ? r_tgt - r_d0 : r_d0 - r_tgt;
            steps = (cyc - r_start) / (r_div + 1);
            if (steps > n) steps = n;
            m_duty = (r_tgt > r_d0) ? r_d0 + steps : r_d0 - steps;
            if (steps == n) begin
                r_act  = 1'b0;
                m_done = 1;
            end
        end
    endtask

    task automatic compare();
        int pwm;
        pwm = int'(bus.pwm_out);
        check("duty",    int'(bus.duty), m_duty);
        check("busy",    int'(bus.busy), int'(r_act));
        check("done",    int'(bus.done), m_done);
        check("pwm_out", pwm, (m_cnt < m_dact) ? 1 : 0);
        busy_cnt += int'(bus.busy);
        done_cnt += int'(bus.done);
        if (glitch_en) begin
            if (m_cnt == 0) begin
                if (g_started)
                    check("glitch_monotonic", (g_high >= g_prev_high) ? 1 : 0, 1);
                g_prev_high = g_high;
                g_high      = 0;
                g_started   = 1'b1;
            end else if (pwm == 1) begin
                check("glitch_contiguous", g_prev_pwm, 1);
            end
            g_high    += pwm;
            g_prev_pwm = pwm;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic drive(input bit st, input int tg, input int dv, input bit rs);
        bus.start    = st;
        bus.target   = R'(tg);
        bus.step_div = SW'(dv);
        reset        = rs;
        tick();
        bus.start = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.done && n < budget);
        if (!bus.done)
            check("wait_done_timeout", 0, 1);
    endtask

    initial begin
        int n, hi, tg, dv;
        bit st, rs;
        bus.start = 1'b0; bus.target = '0; bus.step_div = '0; reset = 1'b1;

        repeat (3) drive(0, 0, 0, 1);
        check("reset_duty", int'(bus.duty), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_pwm",  int'(bus.pwm_out), 0);

        // Up-ramp 0 -> 32 at 4 cycles per step.
        busy_cnt = 0; done_cnt = 0;
        drive(1, 32, 3, 0);
        wait_done(300, n);
        check("up_len",      n, 128);
        check("up_busy_cnt", busy_cnt, 128);
        check("up_done_cnt", done_cnt, 1);
        check("up_duty",     int'(bus.duty), 32);
        repeat (70) tick();
        hi = 0;
        repeat (P) begin
            tick();
            hi += int'(bus.pwm_out);
        end
        check("up_pwm_high", hi, 32);

        // Down-ramp 32 -> 8, one step per cycle.
        drive(1, 8, 0, 0);
        wait_done(100, n);
        check("down_len",  n, 24);
        check("down_duty", int'(bus.duty), 8);
        repeat (5) tick();
        check("down_hold", int'(bus.duty), 8);

        // Null request.
        done_cnt = 0;
        drive(1, 8, 5, 0);
        check("null_done", int'(bus.done), 1);
        check("null_busy", int'(bus.busy), 0);
        tick();
        check("null_done_fall", int'(bus.done), 0);
        check("null_done_cnt", done_cnt, 1);

        // start during a ramp: ignored, or re-targets when enabled.
        done_cnt = 0;
        drive(1, 32, 3, 0);
        repeat (20) tick();
        drive(1, 60, 1, 0);
        wait_done(400, n);
        repeat (10) tick();
        check("busy_start_final", int'(bus.duty), RETARGET ? 60 : 32);
        check("busy_start_dones", done_cnt, 1);

        // Reset 50 cycles into a ramp.
        drive(0, 0, 0, 1);
        drive(1, 32, 3, 0);
        repeat (49) tick();
        drive(0, 0, 0, 1);
        check("rst_mid_duty", int'(bus.duty), 0);
        check("rst_mid_busy", int'(bus.busy), 0);
        check("rst_mid_pwm",  int'(bus.pwm_out), 0);
        done_cnt = 0;
        repeat (200) tick();
        check("rst_mid_no_done", done_cnt, 0);

        // Fast ramp 0 -> 63 watched for period-level glitches.
        drive(1, 63, 0, 0);
        glitch_en = 1'b1;
        repeat (P * 66) tick();
        glitch_en = 1'b0;
        check("glitch_final_duty", int'(bus.duty), 63);
        check("glitch_last_high", g_prev_high, 63);

        // Randomized traffic against the model.
        repeat (3000) begin
            st = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 599) == 0);
            tg = $urandom_range(0, P - 1);
            if ($urandom_range(0, 3) == 0) tg = m_duty;
            dv = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 7);
            drive(st, tg, dv, rs);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
